// File: rtl/pipelined_addsub.sv
// Pipelined integer add/subtract with NZCV flags. Each stage resolves one
// CHUNK-bit slice and registers the carry; the whole pipe advances or stalls as one.
module pipelined_addsub #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_ci,
    input  logic [1:0]       in_op,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_n,
    output logic             out_z,
    output logic             out_c,
    output logic             out_v,
    output logic [TAG_W-1:0] out_tag
);
    localparam int S = WIDTH / CHUNK;

    logic             adv_s;

    logic [S-1:0]     valid_q, valid_d;
    logic [S-1:0]     carry_q, carry_d;
    logic [S-1:0]     zero_q,  zero_d;
    logic             ovf_q,   ovf_d;
    logic [TAG_W-1:0] tag_q [S];
    logic [TAG_W-1:0] tag_d [S];
    logic [WIDTH-1:0] a_q   [S];
    logic [WIDTH-1:0] a_d   [S];
    logic [WIDTH-1:0] b_q   [S];
    logic [WIDTH-1:0] b_d   [S];
    logic [WIDTH-1:0] sum_q [S];
    logic [WIDTH-1:0] sum_d [S];

    // Per-stage inputs: stage 0 is fed from the ports, stage k from register k-1.
    logic [S-1:0]     src_valid_s, src_c_s, src_z_s;
    logic [TAG_W-1:0] src_tag_s [S];
    logic [WIDTH-1:0] src_a_s   [S];
    logic [WIDTH-1:0] src_b_s   [S];
    logic [WIDTH-1:0] src_sum_s [S];
    logic [CHUNK:0]   slice_s   [S];

    assign adv_s    = !out_valid || out_ready;
    assign in_ready = adv_s;

    // Slice adders and next-state for every stage register
    always_comb begin
        src_valid_s[0] = in_valid;
        src_tag_s[0]   = in_tag;
        src_a_s[0]     = in_a;
        src_b_s[0]     = in_op[1] ? ~in_b : in_b;
        src_sum_s[0]   = '0;
        src_c_s[0]     = in_op[0] ? in_ci : in_op[1];
        src_z_s[0]     = 1'b1;
        for (int k = 1; k < S; k++) begin
            src_valid_s[k] = valid_q[k-1];
            src_tag_s[k]   = tag_q[k-1];
            src_a_s[k]     = a_q[k-1];
            src_b_s[k]     = b_q[k-1];
            src_sum_s[k]   = sum_q[k-1];
            src_c_s[k]     = carry_q[k-1];
            src_z_s[k]     = zero_q[k-1];
        end
        for (int k = 0; k < S; k++) begin
            slice_s[k] = {1'b0, src_a_s[k][k*CHUNK +: CHUNK]}
                       + {1'b0, src_b_s[k][k*CHUNK +: CHUNK]}
                       + {{CHUNK{1'b0}}, src_c_s[k]};
            valid_d[k] = src_valid_s[k];
            tag_d[k]   = src_tag_s[k];
            sum_d[k]   = src_sum_s[k];
            sum_d[k][k*CHUNK +: CHUNK] = slice_s[k][CHUNK-1:0];
            a_d[k]     = src_a_s[k];
            a_d[k][k*CHUNK +: CHUNK]   = '0;
            b_d[k]     = src_b_s[k];
            b_d[k][k*CHUNK +: CHUNK]   = '0;
            carry_d[k] = slice_s[k][CHUNK];
            zero_d[k]  = src_z_s[k] & (slice_s[k][CHUNK-1:0] == '0);
        end
        // carry into the MSB is recovered as a ^ b ^ sum at that bit
        ovf_d = slice_s[S-1][CHUNK] ^ slice_s[S-1][CHUNK-1]
              ^ src_a_s[S-1][WIDTH-1] ^ src_b_s[S-1][WIDTH-1];
    end

    // Stage registers: cleared by reset, shift together when the pipe advances
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            carry_q <= '0;
            zero_q  <= '0;
            ovf_q   <= 1'b0;
            for (int k = 0; k < S; k++) begin
                tag_q[k] <= '0;
                a_q[k]   <= '0;
                b_q[k]   <= '0;
                sum_q[k] <= '0;
            end
        end else if (adv_s) begin
            valid_q <= valid_d;
            carry_q <= carry_d;
            zero_q  <= zero_d;
            ovf_q   <= ovf_d;
            for (int k = 0; k < S; k++) begin
                tag_q[k] <= tag_d[k];
                a_q[k]   <= a_d[k];
                b_q[k]   <= b_d[k];
                sum_q[k] <= sum_d[k];
            end
        end
    end

    assign out_valid = valid_q[S-1];
    assign out_sum   = sum_q[S-1];
    assign out_n     = sum_q[S-1][WIDTH-1];
    assign out_z     = zero_q[S-1];
    assign out_c     = carry_q[S-1];
    assign out_v     = ovf_q;
    assign out_tag   = tag_q[S-1];

endmodule

// File: tb/tb_pipelined_addsub.sv
// Scoreboard bench: directed checks on the 32/8 build, random sweeps on 16/4 and 8/8.
module tb_pipelined_addsub;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_ADC = 2'b01;
    localparam logic [1:0] OP_SUB = 2'b10;
    localparam logic [1:0] OP_SBC = 2'b11;

    typedef struct {
        logic [35:0] res;
        logic [3:0]  tag;
        int          acc;
    } ent_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: returns {N, Z, C, V, sum} for a w-bit operation
    function automatic logic [35:0] ref_addsub(input int w, input logic [31:0] a,
                                               input logic [31:0] b, input logic ci,
                                               input logic [1:0] op);
        logic [32:0] full;
        logic [31:0] m, am, bb, s;
        logic        c0, n, z, c, v;
        m    = (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
        am   = a & m;
        bb   = (op[1] ? ~b : b) & m;
        c0   = (op == OP_ADD) ? 1'b0 : ((op == OP_SUB) ? 1'b1 : ci);
        full = {1'b0, am} + {1'b0, bb} + {32'h0, c0};
        s    = full[31:0] & m;
        c    = full[w];
        n    = s[w-1];
        z    = (s == 32'h0);
        v    = (am[w-1] == bb[w-1]) && (s[w-1] != am[w-1]);
        return {n, z, c, v, s};
    endfunction

    // ---------------- directed instance, default parameters ----------------
    logic        d_rst, d_vld, d_rdy, d_ci, d_ovld, d_ordy, d_n, d_z, d_c, d_v;
    logic [31:0] d_a, d_b, d_sum;
    logic [1:0]  d_op;
    logic [3:0]  d_tag, d_otag;
    ent_t        dq[$];

    pipelined_addsub dut (
        .clk(clk), .rst(d_rst), .in_valid(d_vld), .in_ready(d_rdy),
        .in_a(d_a), .in_b(d_b), .in_ci(d_ci), .in_op(d_op), .in_tag(d_tag),
        .out_valid(d_ovld), .out_ready(d_ordy), .out_sum(d_sum),
        .out_n(d_n), .out_z(d_z), .out_c(d_c), .out_v(d_v), .out_tag(d_otag)
    );

    always @(negedge clk) begin
        ent_t e;
        if (d_ovld && d_ordy) begin
            if (dq.size() == 0) begin
                check_eq("dir_unexpected_valid", d_ovld, 1'b0);
            end else begin
                e = dq.pop_front();
                check_eq("dir_result", {d_n, d_z, d_c, d_v, d_sum}, e.res);
                check_eq("dir_tag", d_otag, e.tag);
            end
        end
    end

    task automatic send0(input logic [31:0] a, input logic [31:0] b, input logic ci,
                         input logic [1:0] op, input logic [3:0] tag, input logic [35:0] exp);
        ent_t e;
        d_vld = 1'b1; d_a = a; d_b = b; d_ci = ci; d_op = op; d_tag = tag;
        e.res = exp; e.tag = tag; e.acc = 0;
        dq.push_back(e);
        @(posedge clk); #1;
    endtask

    // ---------------- random sweeps on two other geometries ----------------
    for (genvar g = 0; g < 2; g++) begin : g_sweep
        localparam int W     = (g == 0) ? 16 : 8;
        localparam int C     = (g == 0) ? 4 : 8;
        localparam int S     = W / C;
        localparam int N_OPS = 10000;

        logic         rst_s, vld_s, rdy_s, ci_s, ovld_s, ordy_s, n_s, z_s, c_s, v_s;
        logic [W-1:0] a_s, b_s, sum_s;
        logic [1:0]   op_s;
        logic [3:0]   tag_s, otag_s;
        bit           done = 1'b0;
        int           adv_cnt = 0;
        int           n_out = 0;
        ent_t         q[$];

        pipelined_addsub #(.WIDTH(W), .CHUNK(C), .TAG_W(4)) dut (
            .clk(clk), .rst(rst_s), .in_valid(vld_s), .in_ready(rdy_s),
            .in_a(a_s), .in_b(b_s), .in_ci(ci_s), .in_op(op_s), .in_tag(tag_s),
            .out_valid(ovld_s), .out_ready(ordy_s), .out_sum(sum_s),
            .out_n(n_s), .out_z(z_s), .out_c(c_s), .out_v(v_s), .out_tag(otag_s)
        );

        initial begin : drive
            int issued;
            rst_s = 1'b1; vld_s = 1'b0; a_s = '0; b_s = '0; ci_s = 1'b0;
            op_s = 2'b00; tag_s = 4'h0; ordy_s = 1'b0;
            repeat (3) @(posedge clk);
            #1 rst_s = 1'b0;
            issued = 0;
            while (issued < N_OPS) begin
                vld_s  = ($urandom_range(0, 3) != 0);
                a_s    = W'($urandom);
                b_s    = W'($urandom);
                ci_s   = 1'($urandom);
                op_s   = 2'($urandom);
                tag_s  = 4'($urandom);
                ordy_s = ($urandom_range(0, 3) != 0);
                @(negedge clk);
                if (vld_s && rdy_s) issued++;
                @(posedge clk); #1;
            end
            vld_s  = 1'b0;
            ordy_s = 1'b1;
            repeat (S + 4) @(posedge clk);
            #1;
            check_eq("sweep_drain", q.size(), 0);
            check_eq("sweep_count", n_out, N_OPS);
            done = 1'b1;
        end

        always @(negedge clk) begin
            ent_t e;
            if (!rst_s) begin
                if (rdy_s) adv_cnt++;
                if (vld_s && rdy_s) begin
                    e.res = ref_addsub(W, 32'(a_s), 32'(b_s), ci_s, op_s);
                    e.tag = tag_s;
                    e.acc = adv_cnt;
                    q.push_back(e);
                end
                if (ovld_s && ordy_s) begin
                    if (q.size() == 0) begin
                        check_eq("sweep_unexpected_valid", ovld_s, 1'b0);
                    end else begin
                        e = q.pop_front();
                        n_out++;
                        check_eq("sweep_result", {n_s, z_s, c_s, v_s, 32'(sum_s)}, e.res);
                        check_eq("sweep_tag", otag_s, e.tag);
                        check_eq("sweep_latency", adv_cnt - e.acc, S);
                    end
                end
            end
        end
    end

    // ---------------- directed sequence ----------------
    initial begin : main
        bit all_done;
        d_rst = 1'b1; d_vld = 1'b0; d_a = '0; d_b = '0; d_ci = 1'b0;
        d_op = OP_ADD; d_tag = 4'h0; d_ordy = 1'b1;
        repeat (2) @(posedge clk);
        #1 d_rst = 1'b0;
        @(negedge clk);
        check_eq("reset_valid", d_ovld, 1'b0);
        check_eq("reset_sum", d_sum, 32'h0);
        check_eq("reset_flags", {d_n, d_z, d_c, d_v}, 4'b0000);
        check_eq("reset_tag", d_otag, 4'h0);
        check_eq("reset_ready", d_rdy, 1'b1);
        @(posedge clk); #1;

        // latency of a lone operation
        send0(32'h0000_00FF, 32'h0000_0001, 1'b0, OP_ADD, 4'h5, {4'b0000, 32'h0000_0100});
        d_vld = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("latency_early", d_ovld, 1'b0);
        @(posedge clk);
        @(negedge clk);
        check_eq("latency_exact", d_ovld, 1'b1);
        @(posedge clk); #1;

        // flag corner cases, back to back
        send0(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, OP_ADD, 4'h1, {4'b1001, 32'h8000_0000});
        send0(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, OP_ADC, 4'h2, {4'b0110, 32'h0000_0000});
        send0(32'h0000_0005, 32'h0000_0005, 1'b0, OP_SUB, 4'h3, {4'b0110, 32'h0000_0000});
        send0(32'h0000_0000, 32'h0000_0001, 1'b0, OP_SUB, 4'h4, {4'b1000, 32'hFFFF_FFFF});
        send0(32'h8000_0000, 32'h0000_0000, 1'b0, OP_SBC, 4'h5, {4'b0011, 32'h7FFF_FFFF});
        send0(32'h0000_000A, 32'h0000_0003, 1'b1, OP_SBC, 4'h6, {4'b0010, 32'h0000_0007});
        send0(32'h0000_0001, 32'h0000_0001, 1'b0, OP_ADC, 4'h7, {4'b0000, 32'h0000_0002});
        send0(32'h0000_0002, 32'h0000_0003, 1'b1, OP_ADD, 4'h8, {4'b0000, 32'h0000_0005});
        send0(32'h0000_0003, 32'h0000_0003, 1'b1, OP_SUB, 4'h9, {4'b0110, 32'h0000_0000});
        d_vld = 1'b0;
        repeat (8) @(posedge clk);
        #1;

        // stall: output held for three cycles with tag 1 on the bus
        d_ordy = 1'b0;
        for (int k = 1; k <= 4; k++)
            send0(32'(k * 16), 32'(k), 1'b0, OP_ADD, 4'(k), {4'b0000, 32'(k * 17)});
        d_vld = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("stall_valid", d_ovld, 1'b1);
            check_eq("stall_in_ready", d_rdy, 1'b0);
            check_eq("stall_tag", d_otag, 4'h1);
            check_eq("stall_sum", d_sum, 32'h0000_0011);
            @(posedge clk);
        end
        #1 d_ordy = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            check_eq("drain_valid", d_ovld, 1'b1);
            check_eq("drain_order", d_otag, 4'(k));
            @(posedge clk);
        end
        #1;

        // reset with two operations in flight
        d_vld = 1'b1; d_a = 32'h1; d_b = 32'h1; d_op = OP_ADD; d_tag = 4'hA;
        @(posedge clk); #1;
        d_tag = 4'hB;
        @(posedge clk); #1;
        d_vld = 1'b0; d_rst = 1'b1;
        @(posedge clk); #1;
        d_rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check_eq("flush_valid", d_ovld, 1'b0);
            check_eq("flush_ready", d_rdy, 1'b1);
            @(posedge clk);
        end
        #1;
        send0(32'h0000_0003, 32'h0000_0004, 1'b0, OP_ADD, 4'hC, {4'b0000, 32'h0000_0007});
        d_vld = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        check_eq("dir_leftover", dq.size(), 0);

        all_done = 1'b0;
        for (int i = 0; i < 60000 && !all_done; i++) begin
            @(posedge clk);
            all_done = g_sweep[0].done && g_sweep[1].done;
        end
        check_eq("sweep_finished", all_done, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipelined_addsub.md
# pipelined_addsub

Parametrised, fully pipelined integer add/subtract unit with NZCV flags. It replaces the single-cycle 32-bit carry-lookahead adder in the execute path. Operands are split into CHUNK-bit slices, and one slice is resolved per pipeline stage with the carry registered between stages. A valid/ready handshake with stall support and a sideband tag let the EX stage issue one operation per cycle and match results on return.

## Interface
- WIDTH, 32, operand/result width; must be a multiple of CHUNK.
- CHUNK, 8, bits resolved per stage; S = WIDTH/CHUNK stages (derived, not overridable).
- TAG_W, 4, sideband tag width; tag is carried unchanged alongside the operation.
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  operation present on inputs.
- in_ready  out  1  unit accepts the operation this cycle.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- in_ci  in  1  external carry-in; used only by ADC/SBC.
- in_op  in  2  operation: 00 ADD, 01 ADC, 10 SUB, 11 SBC.
- in_tag  in  TAG_W  sideband tag.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts the result this cycle.
- out_sum  out  WIDTH  result.
- out_n, out_z, out_c, out_v  out  1 each  negative, zero, carry, overflow flags.
- out_tag  out  TAG_W  tag of the result.

## Operation
- Effective operands: B' = in_b for ADD/ADC, ~in_b for SUB/SBC.
- Effective carry-in: c0 = 0 for ADD, 1 for SUB, in_ci for ADC/SBC.
- Sum is modulo 2^WIDTH. C is the carry-out of bit WIDTH-1; for SUB/SBC this is NOT-borrow (1 = no borrow).
- V = carry-out(bit WIDTH-1) XOR carry-into(bit WIDTH-1).
- N = sum[WIDTH-1]. Z = 1 iff all WIDTH sum bits are 0.
- Slice k is computed combinationally in front of stage k from that stage's registered carry. Slice 0 uses c0.
- Each stage register holds:
  - valid;
  - tag;
  - completed sum slices;
  - the remaining unsummed A/B' slices;
  - running carry;
  - a running zero flag, ANDed per slice so no WIDTH-wide compare occurs at the output.
- Stage S-1 is the output register. out_* are driven directly from it with no combinational path from in_* to out_*.
- Pipeline advances as a whole: adv = !out_valid || out_ready. in_ready = adv. All stages shift when adv = 1 and hold when adv = 0.
- Bubbles are not compressed. A stage with valid = 0 shifts like any other stage.
- An operation is accepted when in_valid && in_ready; it enters stage 0 with valid = 1. When in_valid = 0 and adv = 1, a bubble enters stage 0.
- Results leave in acceptance order. Tags are never reordered or altered.

## Timing
- Reset: every stage valid bit, data field and flag resets to 0. After reset, out_valid = 0, out_sum = 0, out_n/z/c/v = 0, out_tag = 0, and in_ready = 1 from the first cycle after reset deasserts.
- Latency: if accepted in cycle t with no stall, out_valid = 1 in cycle t+S. With defaults this is t+4.
- Throughput: one operation per cycle while out_ready = 1.
- Stall: if out_valid = 1 and out_ready = 0, then in_ready = 0 in the same cycle. All stages hold and out_* stay bit-stable until out_ready = 1.
- Simultaneous output handshake and input accept in the same cycle is legal, and both occur.
- If out_valid = 0, in_ready = 1 regardless of out_ready.
- rst asserted mid-operation discards all in-flight operations. out_valid = 0 in the cycle after the reset edge, and no stale result is ever presented.
- in_ci, in_op and in_tag are sampled only on the accept edge.
- WIDTH = CHUNK (S = 1) is legal: single registered stage, latency 1.

## Test plan
- ADD 0x000000FF + 0x00000001 accepted at cycle t -> out_valid at t+4, sum 0x00000100, NZCV = 0000, tag echoed.
- ADD 0x7FFFFFFF + 0x00000001 -> 0x80000000, N = 1, Z = 0, C = 0, V = 1. ADC 0xFFFFFFFF + 0x0 with in_ci = 1 -> 0x00000000, Z = 1, C = 1, V = 0.
- SUB 5 − 5 -> 0x00000000, Z = 1, C = 1. SUB 0 − 1 -> 0xFFFFFFFF, N = 1, C = 0. SBC 0x80000000 − 0 with in_ci = 0 -> 0x7FFFFFFF, V = 1, C = 1.
- Four back-to-back ops, tags 1..4. Hold out_ready = 0 for 3 cycles when tag 1 appears -> in_ready = 0 and outputs stable during the stall; then tags 1..4 arrive in order on consecutive cycles.
- Accept ops at cycles 0 and 1, assert rst in cycle 2 -> out_valid = 0 from cycle 3 onward, no result for either tag, in_ready = 1 after rst drops.
- Parameter sweep: WIDTH = 16/CHUNK = 4 and WIDTH = 8/CHUNK = 8, 10k random ops with random out_ready -> every result and NZCV matches a reference model, latency is S with no stall, and no op is lost or duplicated.
